// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris corner kernel window scheduler.
package harris_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Taps per 3x3 window.
    localparam int TAPS = 9;

    // Row and column offsets of each tap, row-major: tap = (dr+1)*3 + (dc+1).
    localparam int DR [TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int DC [TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/window_addr_gen.sv
// Interior-window walker: row, column and tap counters plus the tap read
// address arithmetic. Counters step on advance and wrap to window (1,1),
// tap 0, after the final tap so the next frame starts clean.
module window_addr_gen
    import harris_pkg::*;
#(
    parameter int N = 8,
    localparam int bitSize = $clog2(N * N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    output logic [bitSize-1:0] raddr,
    output logic [3:0]         tap_idx,
    output logic [bitSize-1:0] center_addr,
    output logic               first,
    output logic               last,
    output logic               final_tap
);

    localparam logic [bitSize-1:0] N_W      = bitSize'(N);
    localparam logic [bitSize-1:0] POS_LO   = bitSize'(1);
    localparam logic [bitSize-1:0] POS_HI   = bitSize'(N - 2);
    localparam logic [3:0]         TAP_LAST = 4'(TAPS - 1);

    logic [bitSize-1:0] r_q;
    logic [bitSize-1:0] c_q;
    logic [3:0]         tap_q;
    logic [bitSize-1:0] row_a;
    logic [bitSize-1:0] col_a;

    // Step tap, then column, then row in raster order; wrap after the last window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= POS_LO;
            c_q   <= POS_LO;
            tap_q <= '0;
        end else if (advance) begin
            if (tap_q == TAP_LAST) begin
                tap_q <= '0;
                if (c_q == POS_HI) begin
                    c_q <= POS_LO;
                    r_q <= (r_q == POS_HI) ? POS_LO : r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end else begin
                tap_q <= tap_q + 1'b1;
            end
        end
    end

    // Tap address (r+dr)*N + (c+dc); modular bitSize arithmetic is exact for interior windows.
    always_comb begin
        row_a       = r_q + bitSize'(DR[tap_q]);
        col_a       = c_q + bitSize'(DC[tap_q]);
        raddr       = row_a * N_W + col_a;
        center_addr = r_q * N_W + c_q;
        tap_idx     = tap_q;
        first       = (tap_q == 4'd0);
        last        = (tap_q == TAP_LAST);
        final_tap   = (tap_q == TAP_LAST) && (r_q == POS_HI) && (c_q == POS_HI);
    end

endmodule

// File: rtl/kernel_window_scheduler.sv
// Frame sequencer: loads a raster frame into the kernel RAM, walks every
// interior 3x3 window issuing nine tap addresses, drains the downstream
// pipeline and pulses done.
// Tap handshake: a tap transfers on a cycle where tap_valid && tap_ready;
// while tap_valid is high and tap_ready is low every tap output holds.
module kernel_window_scheduler
    import harris_pkg::*;
#(
    parameter int N          = 8,
    parameter int pixelWidth = 8,
    parameter int PIPE_DEPTH = 4,
    localparam int bitSize   = $clog2(N * N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [pixelWidth-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [bitSize-1:0]    mem_waddr,
    output logic [pixelWidth-1:0] mem_wdata,
    output logic [bitSize-1:0]    mem_raddr,
    output logic                  tap_valid,
    input  logic                  tap_ready,
    output logic [3:0]            tap_idx,
    output logic                  win_first,
    output logic                  win_last,
    output logic [bitSize-1:0]    center_addr,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_SWEEP = SWEEP;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DW-1:0]      DRAIN_LAST = DW'(PIPE_DEPTH - 1);
    localparam logic [bitSize-1:0] WCNT_LAST  = bitSize'(N * N - 1);

    logic [1:0]         state_q;
    logic [bitSize-1:0] wcnt_q;
    logic [DW-1:0]      dcnt_q;
    logic               tap_valid_q;
    logic               accept;
    logic               advance;

    logic [bitSize-1:0] gen_raddr;
    logic [3:0]         gen_tap_idx;
    logic [bitSize-1:0] gen_center;
    logic               gen_first;
    logic               gen_last;
    logic               gen_final;

    assign accept  = in_valid && in_ready;
    assign advance = tap_valid_q && tap_ready;

    window_addr_gen #(.N(N)) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .raddr       (gen_raddr),
        .tap_idx     (gen_tap_idx),
        .center_addr (gen_center),
        .first       (gen_first),
        .last        (gen_last),
        .final_tap   (gen_final)
    );

    // Registered write port: each accepted beat lands in the RAM one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_waddr <= wcnt_q;
                mem_wdata <= in_data;
            end
        end
    end

    // Frame FSM with write counter, tap-valid register and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            dcnt_q      <= '0;
            tap_valid_q <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            tap_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        wcnt_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (wcnt_q == WCNT_LAST) begin
                            wcnt_q  <= '0;
                            state_q <= ST_SWEEP;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    // First SWEEP cycle keeps tap_valid low so the final write precedes any read.
                    if (advance && gen_final) begin
                        state_q <= ST_DRAIN;
                        dcnt_q  <= '0;
                    end else begin
                        tap_valid_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt_q == DRAIN_LAST) begin
                        dcnt_q  <= '0;
                        done    <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tap outputs are zero whenever no tap is being presented.
    always_comb begin
        in_ready    = (state_q == ST_LOAD);
        busy        = (state_q != ST_IDLE);
        dbg_state   = state_q;
        tap_valid   = tap_valid_q;
        mem_raddr   = tap_valid_q ? gen_raddr   : '0;
        tap_idx     = tap_valid_q ? gen_tap_idx : 4'd0;
        center_addr = tap_valid_q ? gen_center  : '0;
        win_first   = tap_valid_q && gen_first;
        win_last    = tap_valid_q && gen_last;
    end

endmodule

// File: tb/tb_kernel_window_scheduler.sv
// Directed bench for kernel_window_scheduler with N=8, PIPE_DEPTH=4.
module tb_kernel_window_scheduler;

    localparam int N  = 8;
    localparam int PW = 8;
    localparam int BS = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_we;
    logic [BS-1:0] mem_waddr;
    logic [PW-1:0] mem_wdata;
    logic [BS-1:0] mem_raddr;
    logic          tap_valid;
    logic          tap_ready = 1'b1;
    logic [3:0]    tap_idx;
    logic          win_first;
    logic          win_last;
    logic [BS-1:0] center_addr;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int taps_seen;
    int firsts_seen;
    int lasts_seen;

    kernel_window_scheduler #(.N(N), .pixelWidth(PW), .PIPE_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .tap_valid   (tap_valid),
        .tap_ready   (tap_ready),
        .tap_idx     (tap_idx),
        .win_first   (win_first),
        .win_last    (win_last),
        .center_addr (center_addr),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 0);
        check({tag, ".mem_we"}, 32'(mem_we), 0);
        check({tag, ".mem_waddr"}, 32'(mem_waddr), 0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, ".mem_raddr"}, 32'(mem_raddr), 0);
        check({tag, ".tap_valid"}, 32'(tap_valid), 0);
        check({tag, ".tap_idx"}, 32'(tap_idx), 0);
        check({tag, ".win_first"}, 32'(win_first), 0);
        check({tag, ".win_last"}, 32'(win_last), 0);
        check({tag, ".center_addr"}, 32'(center_addr), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".state"}, 32'(dbg_state), 0);
    endtask

    // Driver: feeds 64 pixels (value p^key); gap inserts an idle cycle between beats.
    task automatic load_frame(input bit gap, input logic [7:0] key);
        for (int p = 0; p < N * N; p++) begin
            in_valid = 1'b1;
            in_data  = 8'(p) ^ key;
            tick();
            check("wr.we", 32'(mem_we), 1);
            check("wr.waddr", 32'(mem_waddr), 32'(p));
            check("wr.wdata", 32'(mem_wdata), 32'(8'(p) ^ key));
            check("wr.no_tap", 32'(tap_valid), 0);
            check("wr.in_ready", 32'(in_ready), (p == N * N - 1) ? 0 : 1);
            in_valid = 1'b0;
            if (gap && p != N * N - 1) begin
                tick();
                check("gap.we", 32'(mem_we), 0);
                check("gap.no_tap", 32'(tap_valid), 0);
            end
        end
        tick();
        check("sweep.first_valid", 32'(tap_valid), 1);
        check("sweep.no_write", 32'(mem_we), 0);
        check("sweep.state", 32'(dbg_state), 2);
    endtask

    // Walks all 36 windows against the offset model; optional stall and stray start.
    task automatic sweep_frame(input bit stall_en, input bit poke_start);
        int er;
        int ec;
        taps_seen   = 0;
        firsts_seen = 0;
        lasts_seen  = 0;
        for (int r = 1; r <= N - 2; r++) begin
            for (int c = 1; c <= N - 2; c++) begin
                for (int t = 0; t < 9; t++) begin
                    er = r + t / 3 - 1;
                    ec = c + t % 3 - 1;
                    check("tap.valid", 32'(tap_valid), 1);
                    check("tap.idx", 32'(tap_idx), 32'(t));
                    check("tap.raddr", 32'(mem_raddr), 32'(er * N + ec));
                    check("tap.center", 32'(center_addr), 32'(r * N + c));
                    check("tap.first", 32'(win_first), (t == 0) ? 1 : 0);
                    check("tap.last", 32'(win_last), (t == 8) ? 1 : 0);
                    check("tap.busy", 32'(busy), 1);
                    if (stall_en && r == 3 && c == 5 && t == 4) begin
                        tap_ready = 1'b0;
                        for (int k = 0; k < 3; k++) begin
                            tick();
                            check("stall.valid", 32'(tap_valid), 1);
                            check("stall.raddr", 32'(mem_raddr), 29);
                            check("stall.idx", 32'(tap_idx), 4);
                            check("stall.center", 32'(center_addr), 29);
                            check("stall.first", 32'(win_first), 0);
                            check("stall.last", 32'(win_last), 0);
                        end
                        tap_ready = 1'b1;
                    end
                    if (poke_start && r == 2 && c == 2 && t == 0) start = 1'b1;
                    if (tap_valid === 1'b1) taps_seen++;
                    if (win_first === 1'b1) firsts_seen++;
                    if (win_last === 1'b1) lasts_seen++;
                    tick();
                    start = 1'b0;
                end
            end
        end
        check("sweep.taps", 32'(taps_seen), 324);
        check("sweep.firsts", 32'(firsts_seen), 36);
        check("sweep.lasts", 32'(lasts_seen), 36);
    endtask

    // Sample is cycle T+1 after the last handshake; done must pulse once at T+5.
    task automatic drain_check(input bit restart);
        for (int k = 1; k <= 4; k++) begin
            check("drain.tap_valid", 32'(tap_valid), 0);
            check("drain.done", 32'(done), 0);
            check("drain.busy", 32'(busy), 1);
            check("drain.state", 32'(dbg_state), 3);
            tick();
        end
        check("done.pulse", 32'(done), 1);
        check("done.busy", 32'(busy), 0);
        check("done.state", 32'(dbg_state), 0);
        if (restart) start = 1'b1;
        tick();
        start = 1'b0;
        check("after_done.done", 32'(done), 0);
        check("after_done.in_ready", 32'(in_ready), restart ? 1 : 0);
        check("after_done.state", 32'(dbg_state), restart ? 1 : 0);
    endtask

    initial begin
        // Reset held two cycles with in_valid high.
        in_valid = 1'b1;
        tick();
        check_idle("rst1");
        tick();
        check_idle("rst2");
        rst = 1'b0;
        tick();
        check_idle("idle_in_valid");
        in_valid = 1'b0;

        // Frame 1: gapped load, stalled sweep with stray start, restart on done.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load.in_ready", 32'(in_ready), 1);
        check("load.busy", 32'(busy), 1);
        check("load.state", 32'(dbg_state), 1);
        load_frame(1'b1, 8'h00);
        sweep_frame(1'b1, 1'b1);
        drain_check(1'b1);

        // Frame 2: back-to-back load from waddr 0, then reset mid-sweep.
        load_frame(1'b0, 8'hA5);
        for (int k = 0; k < 5; k++) tick();
        check("mid.state", 32'(dbg_state), 2);
        check("mid.idx", 32'(tap_idx), 5);
        check("mid.raddr", 32'(mem_raddr), 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_rst");
        tick();
        check_idle("mid_rst_hold");

        // Frame 3: clean full frame after the reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load3.in_ready", 32'(in_ready), 1);
        load_frame(1'b0, 8'h3C);
        sweep_frame(1'b0, 1'b0);
        drain_check(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
